load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the core's data-memory port. It accepts one load or store per handshake from the execute stage and generates word addresses, byte enables and lane-shifted write data for the byte-enabled, synchronous-read data memory. It splits misaligned accesses into two word beats and returns aligned, size-adjusted, sign- or zero-extended load data. It sits between the execute/memory pipeline stage and the data memory.

## Interface
Parameters:
- none (32-bit address and data, 4 byte lanes, fixed by RV32)

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  LSU can accept a request; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load only)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `resp_err`  out  1  illegal funct3 in the completed request
- `mem_we`  out  1  write strobe for the current beat
- `mem_byte_en`  out  4  lane enables; bit i corresponds to bits 8i+7:8i
- `mem_addr`  out  32  word-aligned byte address, bits [1:0] = 0
- `mem_wd`  out  32  lane-positioned write data
- `mem_rd`  in  32  read data for the address presented in the previous cycle

## Operation
- Request registered on `req_valid && req_ready`. Let off = addr[1:0]; mask = 0001 (B), 0011 (H), 1111 (W).
- The 8-bit shifted mask `m8 = mask << off` gives beat-1 enables `m8[3:0]` and beat-2 enables `m8[7:4]`. The access is split iff `m8[7:4] != 0`. Split cases: H at off 3; W at off 1, 2 or 3.
- Write data: the 64-bit value `{32'b0, wdata} << 8*off` gives beat-1 `mem_wd` from its low word and beat-2 `mem_wd` from its high word.
- States:
  - **IDLE**: `req_ready` = 1. On accept, go to BEAT1.
  - **BEAT1**: `mem_addr = {addr[31:2], 2'b00}`. Transitions:
    - Illegal funct3: `mem_we` = 0, `resp_valid` = 1, `resp_err` = 1, go to IDLE.
    - Aligned store: `mem_we` = 1, `resp_valid` = 1, go to IDLE.
    - Split store or split load: go to BEAT2.
    - Aligned load: go to RWAIT.
  - **BEAT2**: `mem_addr` = BEAT1 address + 4, with wrap mod 2^32.
    - Store: `mem_we` = 1, `resp_valid` = 1, go to IDLE.
    - Load: capture `mem_rd` (the beat-1 word) into `lo_buf`, go to RWAIT.
  - **RWAIT**: `mem_we` = 0, `resp_valid` = 1, go to IDLE. Load data formation:
    - Aligned: `{32'b0, mem_rd} >> 8*off`.
    - Split: `{mem_rd, lo_buf} >> 8*off`.
    - Take the low 8/16/32 bits, then sign-extend for B/H or zero-extend for BU/HU.
- Outside a write beat: `mem_we` = 0 and `mem_byte_en` = 0. Loads drive `mem_byte_en` = 0; the memory reads the full word.
- `resp_rdata` = 0 when `resp_valid` = 0, for stores, and on error.

## Timing
- Accept at cycle T.
- Aligned store: write beat and `resp_valid` at T+1. `req_ready` returns high at T+2.
- Split store: beats at T+1 and T+2; `resp_valid` at T+2.
- Aligned load: address presented at T+1; `resp_valid` and data at T+2.
- Split load: addresses at T+1 and T+2; `resp_valid` at T+3.
- Illegal funct3: `resp_err` at T+1.
- No back-to-back accept. `req_ready` is low from T+1 until the cycle after `resp_valid`.
- Reset values: state = IDLE; `req_ready` = 1 after the reset cycle. The following are 0: `resp_valid`, `resp_err`, `resp_rdata`, `mem_we`, `mem_byte_en`, `mem_addr`, `mem_wd`, `lo_buf`, and the registered request.
- Reset mid-operation: the in-flight request is dropped with no response and no further beats. A write beat already issued is not undone.
- Address wrap: a split access at 0xFFFFFFFD+ puts beat 2 at 0x00000000.
- `req_*` inputs are ignored outside IDLE.

## Structure
- `lsu_pkg`: funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), state enum `lsu_state_t` {IDLE, BEAT1, BEAT2, RWAIT}, and a size-mask function.
- One combinational sub-module `lsu_align` handles the 64-bit shift, lane extraction and sign/zero extension for the load path. The store-path shift stays inline.
- Target size: roughly 200 lines of RTL.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF → T+1: `mem_addr` 0x100, `mem_byte_en` 1111, `mem_wd` 0xDEADBEEF, `resp_valid` 1.
- SB addr 0x103, wdata 0x000000AB → `mem_byte_en` 1000, `mem_wd` 0xAB000000; then LB 0x103 → `resp_rdata` 0xFFFFFFAB and LBU → 0x000000AB, each at T+2.
- Memory holds [0x200] = 0x44332211, [0x204] = 0x88776655. LW addr 0x202 → beats at 0x200 and 0x204, `resp_rdata` 0x66554433 at T+3.
- SH addr 0x20B, wdata 0x0000CDEF → beat 1: `mem_addr` 0x208, be 1000, wd 0xEF000000. Beat 2: `mem_addr` 0x20C, be 0001, wd 0x000000CD. `resp_valid` at T+2.
- funct3 = 011 load → `resp_err` 1 at T+1, `mem_we` never 1, `resp_rdata` 0.
- `reset` asserted in BEAT2 of a split store → no second write beat, no `resp_valid`, all outputs 0 next cycle, `req_ready` 1 after reset release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, LSU state enum and access size mask
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RWAIT} lsu_state_t;
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : f3[1:0] == 2'b10 ? 4'b1111 : 4'b0000;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: execute-side request/response and data-memory bus; slave = LSU, master = execute stage plus memory
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_byte_en, mem_addr, mem_wd
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_byte_en, mem_addr, mem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: shifts a 64-bit load window by off bytes and sign/zero-extends B/H/W (in: data, off, funct3; out: rdata)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  assign sh = 32'(data >> {off, 3'b000});
  assign rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                 funct3 == F3_BU ? {24'b0, sh[7:0]} :
                 funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                 funct3 == F3_HU ? {16'b0, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 data-memory initiator splitting misaligned accesses (ports: clk, reset, bus = lsu_if.slave)
module load_store_unit
  import lsu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);
  lsu_state_t  state, state_n;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, lo_buf, base, ld_data;
  logic [1:0]  off;
  logic [7:0]  m8;
  logic [63:0] wd64, rd64;
  logic        split, legal, accept;
  assign off = addr_q[1:0];
  assign m8 = {4'b0000, size_mask(f3_q)} << off;
  assign split = |m8[7:4];
  assign wd64 = {32'b0, wdata_q} << {off, 3'b000};
  assign rd64 = split ? {bus.mem_rd, lo_buf} : {32'b0, bus.mem_rd};
  assign base = {addr_q[31:2], 2'b00};
  assign legal = (f3_q inside {F3_B, F3_H, F3_W}) || (!we_q && (f3_q inside {F3_BU, F3_HU}));
  assign accept = bus.req_valid && bus.req_ready;
  lsu_align u_align (.data(rd64), .off(off), .funct3(f3_q), .rdata(ld_data));
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      lo_buf  <= 32'h0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == BEAT2 && !we_q) lo_buf <= bus.mem_rd;
    end
  end
  // Outputs are held at zero while reset is high so a reset landing on BEAT2 suppresses the second write.
  always_comb begin
    state_n         = state;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_err    = 1'b0;
    bus.resp_rdata  = 32'h0;
    bus.mem_we      = 1'b0;
    bus.mem_byte_en = 4'b0000;
    bus.mem_addr    = 32'h0;
    bus.mem_wd      = 32'h0;
    if (!reset) begin
      case (state)
        IDLE: begin
          bus.req_ready = 1'b1;
          state_n = bus.req_valid ? BEAT1 : IDLE;
        end
        BEAT1: begin
          bus.mem_addr = base;
          if (!legal) begin
            bus.resp_valid = 1'b1;
            bus.resp_err = 1'b1;
            state_n = IDLE;
          end else if (we_q) begin
            bus.mem_we = 1'b1;
            bus.mem_byte_en = m8[3:0];
            bus.mem_wd = wd64[31:0];
            bus.resp_valid = !split;
            state_n = split ? BEAT2 : IDLE;
          end else begin
            state_n = split ? BEAT2 : RWAIT;
          end
        end
        BEAT2: begin
          bus.mem_addr = base + 32'd4;
          if (we_q) begin
            bus.mem_we = 1'b1;
            bus.mem_byte_en = m8[7:4];
            bus.mem_wd = wd64[63:32];
            bus.resp_valid = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = RWAIT;
          end
        end
        RWAIT: begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = ld_data;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit against a byte-addressed reference memory
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  lsu_if bus();
  load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] ram [logic [29:0]];
  logic [7:0]  refm [logic [31:0]];
  logic [31:0] mw;
  int total = 0;
  int bad = 0;
  int lat, nwr;
  logic [31:0] r_rdata;
  logic r_err, busy_ok, ready_after;
  logic [31:0] b_addr [8];
  logic [3:0]  b_be [8];
  logic [31:0] b_wd [8];
  logic        b_we [8];
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return ram.exists(a[31:2]) ? ram[a[31:2]] : 32'h0;
  endfunction
  always @(posedge clk) begin
    bus.mem_rd <= rd_word(bus.mem_addr);
    if (bus.mem_we) begin
      mw = rd_word(bus.mem_addr);
      for (int i = 0; i < 4; i++) if (bus.mem_byte_en[i]) mw[8*i+:8] = bus.mem_wd[8*i+:8];
      ram[bus.mem_addr[31:2]] = mw;
    end
  end
  function automatic int nbytes(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction
  function automatic bit is_legal(input logic we, input logic [2:0] f3);
    return (f3 inside {3'd0, 3'd1, 3'd2}) || (!we && (f3 inside {3'd4, 3'd5}));
  endfunction
  function automatic int exp_lat(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit sp;
    sp = int'(a[1:0]) + nbytes(f3) > 4;
    if (!is_legal(we, f3)) return 1;
    return we ? (sp ? 2 : 1) : (sp ? 3 : 2);
  endfunction
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] p;
    v = 32'h0;
    for (int i = 0; i < nbytes(f3); i++) begin
      p = a + 32'(i);
      v[8*i+:8] = refm.exists(p) ? refm[p] : 8'h00;
    end
    case (f3)
      3'd0: return {{24{v[7]}}, v[7:0]};
      3'd1: return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction
  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(f3); i++) refm[a + 32'(i)] = wd[8*i+:8];
  endtask
  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    ram[a[31:2]] = w;
    for (int i = 0; i < 4; i++) refm[{a[31:2], 2'b00} + 32'(i)] = w[8*i+:8];
  endtask
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int k;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    nwr = 0;
    busy_ok = 1'b1;
    r_rdata = 32'h0;
    r_err = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      b_addr[c-1] = bus.mem_addr;
      b_be[c-1] = bus.mem_byte_en;
      b_wd[c-1] = bus.mem_wd;
      b_we[c-1] = bus.mem_we;
      nwr += int'(bus.mem_we);
      busy_ok &= !bus.req_ready;
      if (bus.resp_valid) begin
        lat = c;
        r_rdata = bus.resp_rdata;
        r_err = bus.resp_err;
      end else @(negedge clk);
    end
    @(negedge clk);
    ready_after = bus.req_ready;
  endtask
  task automatic test_reset;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", bus.req_ready);
    end
    total++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mem_we, bus.mem_byte_en, bus.mem_addr, bus.mem_wd} !== 103'h0) begin
      bad++;
      $display("FAIL reset_outputs: rv=%b err=%b rd=%h we=%b be=%b addr=%h wd=%h want all 0",
               bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.mem_we, bus.mem_byte_en, bus.mem_addr, bus.mem_wd);
    end
  endtask
  task automatic test_store_word;
    do_req(1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
    ref_store(3'd2, 32'h100, 32'hDEADBEEF);
    total++;
    if ({lat, b_addr[0], b_be[0], b_wd[0], b_we[0], r_rdata} !== {32'd1, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL sw_beat: lat=%0d addr=%h be=%b wd=%h we=%b rd=%h want 1 00000100 1111 deadbeef 1 0",
               lat, b_addr[0], b_be[0], b_wd[0], b_we[0], r_rdata);
    end
    total++;
    if ({busy_ok, ready_after} !== 2'b11) begin
      bad++;
      $display("FAIL sw_ready: busy_ok=%b ready_after=%b want 1 1", busy_ok, ready_after);
    end
  endtask
  task automatic test_byte;
    do_req(1'b1, 3'd0, 32'h103, 32'h000000AB);
    ref_store(3'd0, 32'h103, 32'h000000AB);
    total++;
    if ({lat, b_addr[0], b_be[0], b_wd[0], b_we[0]} !== {32'd1, 32'h100, 4'b1000, 32'hAB000000, 1'b1}) begin
      bad++;
      $display("FAIL sb_beat: lat=%0d addr=%h be=%b wd=%h we=%b want 1 00000100 1000 ab000000 1",
               lat, b_addr[0], b_be[0], b_wd[0], b_we[0]);
    end
    do_req(1'b0, 3'd0, 32'h103, 32'h0);
    total++;
    if ({lat, r_rdata, b_addr[0], b_be[0], nwr} !== {32'd2, 32'hFFFFFFAB, 32'h100, 4'b0000, 32'd0}) begin
      bad++;
      $display("FAIL lb: lat=%0d rd=%h addr=%h be=%b nwr=%0d want 2 ffffffab 00000100 0000 0", lat, r_rdata, b_addr[0], b_be[0], nwr);
    end
    do_req(1'b0, 3'd4, 32'h103, 32'h0);
    total++;
    if ({lat, r_rdata} !== {32'd2, 32'h000000AB}) begin
      bad++;
      $display("FAIL lbu: lat=%0d rd=%h want 2 000000ab", lat, r_rdata);
    end
  endtask
  task automatic test_split_load;
    preload(32'h200, 32'h44332211);
    preload(32'h204, 32'h88776655);
    do_req(1'b0, 3'd2, 32'h202, 32'h0);
    total++;
    if ({lat, b_addr[0], b_addr[1], r_rdata, nwr} !== {32'd3, 32'h200, 32'h204, 32'h66554433, 32'd0}) begin
      bad++;
      $display("FAIL lw_split: lat=%0d a1=%h a2=%h rd=%h nwr=%0d want 3 00000200 00000204 66554433 0",
               lat, b_addr[0], b_addr[1], r_rdata, nwr);
    end
    do_req(1'b0, 3'd1, 32'h203, 32'h0);
    total++;
    if ({lat, r_rdata} !== {32'd3, ref_load(3'd1, 32'h203)}) begin
      bad++;
      $display("FAIL lh_split: lat=%0d rd=%h want 3 %h", lat, r_rdata, ref_load(3'd1, 32'h203));
    end
    do_req(1'b0, 3'd1, 32'h206, 32'h0);
    total++;
    if ({lat, r_rdata} !== {32'd2, 32'hFFFF8877}) begin
      bad++;
      $display("FAIL lh_neg: lat=%0d rd=%h want 2 ffff8877", lat, r_rdata);
    end
  endtask
  task automatic test_split_store;
    do_req(1'b1, 3'd1, 32'h20B, 32'h0000CDEF);
    ref_store(3'd1, 32'h20B, 32'h0000CDEF);
    total++;
    if ({lat, b_addr[0], b_be[0], b_wd[0], b_we[0]} !== {32'd2, 32'h208, 4'b1000, 32'hEF000000, 1'b1}) begin
      bad++;
      $display("FAIL sh_beat1: lat=%0d addr=%h be=%b wd=%h we=%b want 2 00000208 1000 ef000000 1",
               lat, b_addr[0], b_be[0], b_wd[0], b_we[0]);
    end
    total++;
    if ({b_addr[1], b_be[1], b_wd[1], b_we[1]} !== {32'h20C, 4'b0001, 32'h000000CD, 1'b1}) begin
      bad++;
      $display("FAIL sh_beat2: addr=%h be=%b wd=%h we=%b want 0000020c 0001 000000cd 1", b_addr[1], b_be[1], b_wd[1], b_we[1]);
    end
  endtask
  task automatic test_illegal;
    logic [2:0] f3s [3] = '{3'd3, 3'd6, 3'd4};
    logic       wes [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_req(wes[i], f3s[i], 32'h200, 32'hFFFFFFFF);
      total++;
      if ({lat, r_err, r_rdata, nwr} !== {32'd1, 1'b1, 32'h0, 32'd0}) begin
        bad++;
        $display("FAIL illegal_%0d: lat=%0d err=%b rd=%h nwr=%0d want 1 1 0 0", i, lat, r_err, r_rdata, nwr);
      end
    end
  endtask
  task automatic test_wrap;
    preload(32'hFFFFFFFC, 32'hA0B0C0D0);
    preload(32'h00000000, 32'h11223344);
    do_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0);
    total++;
    if ({lat, b_addr[0], b_addr[1], r_rdata} !== {32'd3, 32'hFFFFFFFC, 32'h0, 32'h3344A0B0}) begin
      bad++;
      $display("FAIL wrap_lw: lat=%0d a1=%h a2=%h rd=%h want 3 fffffffc 00000000 3344a0b0", lat, b_addr[0], b_addr[1], r_rdata);
    end
    do_req(1'b1, 3'd2, 32'hFFFFFFFD, 32'h12345678);
    ref_store(3'd2, 32'hFFFFFFFD, 32'h12345678);
    total++;
    if ({b_addr[0], b_be[0], b_wd[0], b_addr[1], b_be[1], b_wd[1]} !== {32'hFFFFFFFC, 4'b1110, 32'h34567800, 32'h0, 4'b0001, 32'h00000012}) begin
      bad++;
      $display("FAIL wrap_sw: a1=%h be1=%b wd1=%h a2=%h be2=%b wd2=%h want fffffffc 1110 34567800 00000000 0001 00000012",
               b_addr[0], b_be[0], b_wd[0], b_addr[1], b_be[1], b_wd[1]);
    end
    total++;
    if ({rd_word(32'hFFFFFFFC), rd_word(32'h0)} !== {32'h345678D0, 32'h11223312}) begin
      bad++;
      $display("FAIL wrap_mem: hi=%h lo=%h want 345678d0 11223312", rd_word(32'hFFFFFFFC), rd_word(32'h0));
    end
  endtask
  task automatic test_reset_mid;
    logic w1;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'd1;
    bus.req_addr = 32'h20B;
    bus.req_wdata = 32'h00001357;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    w1 = bus.mem_we;
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if ({w1, bus.mem_we, bus.mem_byte_en, bus.resp_valid} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid: beat1_we=%b we=%b be=%b rv=%b want 1 0 0000 0", w1, bus.mem_we, bus.mem_byte_en, bus.resp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.mem_we, bus.mem_addr, bus.mem_wd} !== {1'b1, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL rst_release: ready=%b rv=%b we=%b addr=%h wd=%h want 1 0 0 0 0",
               bus.req_ready, bus.resp_valid, bus.mem_we, bus.mem_addr, bus.mem_wd);
    end
    refm[32'h20B] = 8'h57;
    total++;
    if ({rd_word(32'h208), rd_word(32'h20C)} !== {ref_load(3'd2, 32'h208), ref_load(3'd2, 32'h20C)}) begin
      bad++;
      $display("FAIL rst_mem: w208=%h w20c=%h want %h %h", rd_word(32'h208), rd_word(32'h20C),
               ref_load(3'd2, 32'h208), ref_load(3'd2, 32'h20C));
    end
  endtask
  task automatic test_back_to_back;
    logic [5:0] rdy, rv;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'd2;
    for (int k = 0; k < 6; k++) begin
      bus.req_addr = 32'h400 + 32'(4 * k);
      bus.req_wdata = 32'hC0DE0000 + 32'(k);
      #1;
      rdy[k] = bus.req_ready;
      rv[k] = bus.resp_valid;
      if (bus.req_ready) ref_store(3'd2, bus.req_addr, bus.req_wdata);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rdy, rv} !== {6'b010101, 6'b101010}) begin
      bad++;
      $display("FAIL b2b_pattern: ready=%b resp=%b want 010101 101010", rdy, rv);
    end
    total++;
    if ({rd_word(32'h400), rd_word(32'h404), rd_word(32'h408), rd_word(32'h410)} !== {32'hC0DE0000, 32'h0, 32'hC0DE0002, 32'hC0DE0004}) begin
      bad++;
      $display("FAIL b2b_mem: %h %h %h %h want c0de0000 00000000 c0de0002 c0de0004",
               rd_word(32'h400), rd_word(32'h404), rd_word(32'h408), rd_word(32'h410));
    end
  endtask
  task automatic test_random;
    logic we;
    logic [2:0] f3;
    logic [31:0] a, wd, exp_rd;
    int exp_w;
    for (int w = 0; w < 18; w++) preload(32'h3000 + 32'(4 * w), $urandom);
    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f3 = $urandom_range(0, 9) < 8 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      if (!we && $urandom_range(0, 2) == 0) f3 = $urandom_range(0, 1) ? 3'd4 : 3'd5;
      a = 32'h3000 + 32'($urandom_range(0, 59));
      wd = $urandom;
      exp_rd = (!we && is_legal(we, f3)) ? ref_load(f3, a) : 32'h0;
      exp_w = (we && is_legal(we, f3)) ? (int'(a[1:0]) + nbytes(f3) > 4 ? 2 : 1) : 0;
      do_req(we, f3, a, wd);
      if (we && is_legal(we, f3)) ref_store(f3, a, wd);
      total++;
      if ({lat, r_err, r_rdata, nwr} !== {exp_lat(we, f3, a), !is_legal(we, f3), exp_rd, exp_w}) begin
        bad++;
        $display("FAIL rand_%0d we=%b f3=%0d a=%h: lat=%0d err=%b rd=%h nwr=%0d want %0d %b %h %0d", n, we, f3, a,
                 lat, r_err, r_rdata, nwr, exp_lat(we, f3, a), !is_legal(we, f3), exp_rd, exp_w);
      end
    end
    for (int w = 0; w < 18; w++) begin
      a = 32'h3000 + 32'(4 * w);
      total++;
      if (rd_word(a) !== ref_load(3'd2, a)) begin
        bad++;
        $display("FAIL rand_mem %h: got %h want %h", a, rd_word(a), ref_load(3'd2, a));
      end
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_store_word();
    test_byte();
    test_split_load();
    test_split_store();
    test_illegal();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
